// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer control slice.
package countdown_pkg;

  localparam int STATE_W         = 2;
  localparam int SEC_W           = 6;
  localparam int SEC_MAX         = 59;
  localparam int DEFAULT_MAX_MIN = 99;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between the input decoders, the sequencer and the
// display/alarm consumers. The sequencer is the slave; the driver side is master.
interface countdown_sequencer_if #(
  parameter int MIN_W = 7
);
  import countdown_pkg::*;

  logic                tick_i;
  logic                start_i;
  logic                sec_inc;
  logic                sec_dec;
  logic                min_inc;
  logic                min_dec;
  logic [MIN_W-1:0]    minutes;
  logic [SEC_W-1:0]    seconds;
  logic [STATE_W-1:0]  state_o;
  logic                running;
  logic                alarm;

  modport master (
    output tick_i, start_i, sec_inc, sec_dec, min_inc, min_dec,
    input  minutes, seconds, state_o, running, alarm
  );

  modport slave (
    input  tick_i, start_i, sec_inc, sec_dec, min_inc, min_dec,
    output minutes, seconds, state_o, running, alarm
  );

endinterface

// File: rtl/countdown_edge_det.sv
// Registers the start button level and emits a one-cycle pulse on its rising
// edge. History resets to 1 so a button held through reset does not fire.
module countdown_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // previous-level register, preset high on reset
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b1;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/countdown_sequencer.sv
// Central countdown control FSM: owns the mm:ss value, applies encoder edits,
// counts down on the 1 Hz tick and drives the alarm pattern at expiry.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int MAX_MIN     = DEFAULT_MAX_MIN,
  parameter int ALARM_TICKS = 10,
  parameter int MIN_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(ALARM_TICKS + 1);

  localparam logic [MIN_W-1:0] MIN_TOP   = MIN_W'(MAX_MIN);
  localparam logic [MIN_W-1:0] MIN_ONE   = MIN_W'(1);
  localparam logic [SEC_W-1:0] SEC_TOP   = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ALARM_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_n;
  logic [MIN_W-1:0]   min_q, min_n, min_ed;
  logic [SEC_W-1:0]   sec_q, sec_n, sec_ed;
  logic [MIN_W-1:0]   pmin_q, pmin_n;
  logic [SEC_W-1:0]   psec_q, psec_n;
  logic               alarm_q, alarm_n;
  logic               running_q, running_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               start_evt;
  logic               time_nz;

  countdown_edge_det u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.start_i),
    .rise (start_evt)
  );

  // edited time candidates: seconds wrap, minutes saturate, inc+dec cancels
  always_comb begin
    sec_ed = sec_q;
    min_ed = min_q;
    if (bus.sec_inc && !bus.sec_dec)
      sec_ed = (sec_q >= SEC_TOP) ? '0 : sec_q + SEC_ONE;
    else if (bus.sec_dec && !bus.sec_inc)
      sec_ed = (sec_q == '0) ? SEC_TOP : sec_q - SEC_ONE;
    if (bus.min_inc && !bus.min_dec)
      min_ed = (min_q >= MIN_TOP) ? MIN_TOP : min_q + MIN_ONE;
    else if (bus.min_dec && !bus.min_inc)
      min_ed = (min_q == '0) ? '0 : min_q - MIN_ONE;
  end

  assign time_nz = (min_q != '0) || (sec_q != '0);

  // next-state and next-datapath; priority start_evt > tick_i > edits
  always_comb begin
    state_n = state_q;
    min_n   = min_q;
    sec_n   = sec_q;
    pmin_n  = pmin_q;
    psec_n  = psec_q;
    alarm_n = alarm_q;
    cnt_n   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_evt && time_nz) begin
          state_n = ST_RUN;
          pmin_n  = min_q;
          psec_n  = sec_q;
        end else begin
          min_n = min_ed;
          sec_n = sec_ed;
        end
      end

      ST_RUN: begin
        if (start_evt) begin
          state_n = ST_PAUSE;
        end else if (bus.tick_i) begin
          if (sec_q != '0) begin
            sec_n = sec_q - SEC_ONE;
          end else begin
            sec_n = SEC_TOP;
            min_n = min_q - MIN_ONE;
          end
          // only 0:01 reaches 0:00 on this tick
          if (min_q == '0 && sec_q == SEC_ONE) begin
            state_n = ST_ALARM;
            alarm_n = 1'b1;
            cnt_n   = '0;
          end
        end
      end

      ST_PAUSE: begin
        if (start_evt) begin
          state_n = time_nz ? ST_RUN : ST_IDLE;
        end else begin
          min_n = min_ed;
          sec_n = sec_ed;
        end
      end

      ST_ALARM: begin
        if (start_evt || (bus.tick_i && cnt_q == CNT_LAST)) begin
          state_n = ST_IDLE;
          min_n   = pmin_q;
          sec_n   = psec_q;
          alarm_n = 1'b0;
        end else if (bus.tick_i) begin
          cnt_n   = cnt_q + CNT_ONE;
          alarm_n = ~alarm_q;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    running_n = (state_n == ST_RUN);
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      pmin_q    <= '0;
      psec_q    <= '0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_n;
      min_q     <= min_n;
      sec_q     <= sec_n;
      pmin_q    <= pmin_n;
      psec_q    <= psec_n;
      alarm_q   <= alarm_n;
      running_q <= running_n;
      cnt_q     <= cnt_n;
    end
  end

  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.state_o = state_q;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer: expected values are hand-derived.
module tb_countdown_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  countdown_sequencer_if #(.MIN_W(7)) bus ();

  countdown_sequencer #(
    .MAX_MIN     (99),
    .ALARM_TICKS (10),
    .MIN_W       (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int m, input int s);
    check({tag, ".min"}, 32'(bus.minutes), 32'(m));
    check({tag, ".sec"}, 32'(bus.seconds), 32'(s));
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.tick_i = 1'b1; cycle(); bus.tick_i = 1'b0;
  endtask

  task automatic press();
    bus.start_i = 1'b1; cycle(); bus.start_i = 1'b0;
  endtask

  task automatic sec_up(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sec_inc = 1'b1; cycle(); bus.sec_inc = 1'b0;
    end
  endtask

  task automatic sec_down(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sec_dec = 1'b1; cycle(); bus.sec_dec = 1'b0;
    end
  endtask

  task automatic min_up(input int n);
    for (int i = 0; i < n; i++) begin
      bus.min_inc = 1'b1; cycle(); bus.min_inc = 1'b0;
    end
  endtask

  initial begin
    bus.tick_i = 1'b0; bus.start_i = 1'b1;
    bus.sec_inc = 1'b0; bus.sec_dec = 1'b0;
    bus.min_inc = 1'b0; bus.min_dec = 1'b0;

    // reset with the button held down
    rst = 1'b1; cycle(); cycle();
    check("rst.state", 32'(bus.state_o), 0);
    check_time("rst", 0, 0);
    check("rst.alarm", 32'(bus.alarm), 0);
    check("rst.running", 32'(bus.running), 0);
    rst = 1'b0; cycle(); cycle();
    sec_up(1);
    cycle();
    check("held.state", 32'(bus.state_o), 0);
    bus.start_i = 1'b0;
    sec_down(1);
    cycle();

    // 0:05 countdown to alarm and auto-return
    sec_up(5);
    check_time("set5", 0, 5);
    press();
    check("run.state", 32'(bus.state_o), 1);
    check("run.running", 32'(bus.running), 1);
    for (int i = 0; i < 4; i++) tick();
    check_time("t4", 0, 1);
    check("t4.state", 32'(bus.state_o), 1);
    tick();
    check_time("t5", 0, 0);
    check("t5.state", 32'(bus.state_o), 3);
    check("t5.alarm", 32'(bus.alarm), 1);
    check("t5.running", 32'(bus.running), 0);
    tick();
    check("a1.alarm", 32'(bus.alarm), 0);
    for (int i = 0; i < 8; i++) tick();
    check("a9.state", 32'(bus.state_o), 3);
    check("a9.alarm", 32'(bus.alarm), 0);
    tick();
    check("a10.state", 32'(bus.state_o), 0);
    check_time("a10", 0, 5);
    check("a10.alarm", 32'(bus.alarm), 0);

    // 1:00 borrow and edits ignored while running
    sec_down(5);
    min_up(1);
    check_time("set100", 1, 0);
    press();
    tick();
    check_time("borrow", 0, 59);
    min_up(1);
    check_time("runedit", 0, 59);
    check("runedit.state", 32'(bus.state_o), 1);

    // start and tick together pause without decrementing
    for (int i = 0; i < 29; i++) tick();
    check_time("at30", 0, 30);
    bus.start_i = 1'b1; bus.tick_i = 1'b1; cycle();
    bus.start_i = 1'b0; bus.tick_i = 1'b0;
    check("pause.state", 32'(bus.state_o), 2);
    check_time("pause", 0, 30);
    tick();
    check_time("pausetick", 0, 30);
    press();
    check("resume.state", 32'(bus.state_o), 1);

    // edits in PAUSE, then reset from RUN at 0:42
    cycle();
    press();
    check("pause2.state", 32'(bus.state_o), 2);
    sec_up(12);
    check_time("pauseedit", 0, 42);
    press();
    check("run42.state", 32'(bus.state_o), 1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rstrun.state", 32'(bus.state_o), 0);
    check_time("rstrun", 0, 0);
    check("rstrun.alarm", 32'(bus.alarm), 0);
    check("rstrun.running", 32'(bus.running), 0);

    // start at 0:00 is ignored
    press();
    check("zero.state", 32'(bus.state_o), 0);

    // edit boundaries
    sec_down(1);
    check_time("secwrapdn", 0, 59);
    sec_up(1);
    check_time("secwrapup", 0, 0);
    bus.min_dec = 1'b1; cycle(); bus.min_dec = 1'b0;
    check_time("minfloor", 0, 0);
    min_up(100);
    check_time("minsat", 99, 0);
    bus.sec_inc = 1'b1; bus.min_dec = 1'b1; cycle();
    bus.sec_inc = 1'b0; bus.min_dec = 1'b0;
    check_time("bothfields", 98, 1);
    bus.sec_inc = 1'b1; bus.sec_dec = 1'b1; cycle();
    bus.sec_inc = 1'b0; bus.sec_dec = 1'b0;
    check_time("cancel", 98, 1);

    // start with simultaneous edit uses the pre-edit value as preset
    rst = 1'b1; cycle(); rst = 1'b0;
    sec_up(3);
    bus.start_i = 1'b1; bus.sec_inc = 1'b1; cycle();
    bus.start_i = 1'b0; bus.sec_inc = 1'b0;
    check("startedit.state", 32'(bus.state_o), 1);
    check_time("startedit", 0, 3);
    for (int i = 0; i < 3; i++) tick();
    check("alarm2.state", 32'(bus.state_o), 3);
    tick();
    check("alarm2.a1", 32'(bus.alarm), 0);
    tick();
    check("alarm2.a2", 32'(bus.alarm), 1);
    bus.start_i = 1'b1; bus.tick_i = 1'b1; cycle();
    bus.start_i = 1'b0; bus.tick_i = 1'b0;
    check("abort.state", 32'(bus.state_o), 0);
    check("abort.alarm", 32'(bus.alarm), 0);
    check_time("abort", 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Central control FSM for the countdown timer: owns the minutes/seconds count, accepts set-up steps from the encoder decoders, and decrements on the 1 Hz strobe.
- Raises the alarm at expiry.
- Sits between the encoder quadrature decoders / countdown button input and the 7-segment display driver / PWM alarm generator; it is the only writer of the time value.

Parameters:
- MAX_MIN, 99, highest settable minutes value (minutes saturate here)
- ALARM_TICKS, 10, number of tick_i strobes the ALARM state lasts before auto-return to IDLE
- MIN_W, 7, width of minutes output; must hold MAX_MIN

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick_i  in  1  one-cycle 1 Hz strobe from prescaler
- start_i  in  1  debounced countdown button level; rising edge detected internally
- sec_inc  in  1  one-cycle pulse, seconds +1
- sec_dec  in  1  one-cycle pulse, seconds -1
- min_inc  in  1  one-cycle pulse, minutes +1
- min_dec  in  1  one-cycle pulse, minutes -1
- minutes  out  MIN_W  current minutes, binary
- seconds  out  6  current seconds, binary 0..59
- state_o  out  2  FSM state code (IDLE=0, RUN=1, PAUSE=2, ALARM=3)
- running  out  1  high in RUN
- alarm  out  1  alarm pattern: toggles on each tick_i in ALARM, 0 elsewhere

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; minutes=0, seconds=0, preset=0; alarm=0; running=0.
  - Edge-detector history set to 1, so a held button does not fire after reset.
  - Reset mid-operation aborts any state with the same result.
- All outputs are registered. Effects appear the cycle after the input is sampled.
- Start edge: start_evt = start_i & ~start_q (start_q is the registered previous level).
- IDLE:
  - Edit pulses apply.
  - start_evt with time≠0 → RUN; preset←{minutes,seconds}.
  - start_evt with time=0 → ignored.
- RUN:
  - tick_i decrements the time. If seconds>0: seconds-1. Else seconds←59 and minutes-1.
  - A tick that makes the time 0:00 → ALARM in the same update; alarm←1, alarm tick counter←0.
  - start_evt → PAUSE.
  - Edit pulses are ignored.
- PAUSE:
  - Edit pulses apply.
  - start_evt: time≠0 → RUN; time=0 → IDLE.
  - tick_i is ignored.
- ALARM:
  - Each tick_i toggles alarm and increments the counter.
  - When the counter reaches ALARM_TICKS, or on start_evt: → IDLE, time←preset, alarm←0.
  - Edit pulses are ignored.
- Edit rules:
  - Seconds wrap with no carry: 59+1→0, 0-1→59.
  - Minutes saturate: MAX_MIN+1 stays MAX_MIN; 0-1 stays 0.
  - inc and dec of the same field in the same cycle cancel (no change).
  - Seconds and minutes edits in the same cycle both apply.
- Priority in one cycle: rst > start_evt > tick_i > edits.
  - RUN with start_evt and tick_i together → PAUSE; the tick is discarded.
  - ALARM with start_evt and tick_i together → IDLE; no toggle.
  - IDLE with start_evt and edits together → RUN; preset and count use the pre-edit value.
- ALARM counter width is clog2(ALARM_TICKS+1). It is not used outside ALARM.

Decomposition:
- Shared package countdown_pkg:
  - state enum typedef and codes
  - SEC_MAX=59 constant
  - default MAX_MIN
  - state_o width
- Natural sub-module: countdown_edge_det (start_i synchroniser register plus rising-edge pulse, reset value 1).
- The rest stays flat in countdown_sequencer.

Test Plan:
- Reset, set 0:05 via 5 sec_inc pulses, start edge → state RUN. Then 5 ticks → time 0:00, state ALARM, alarm=1 after the 5th tick. Then 10 more ticks → state IDLE, time 0:05, alarm=0.
- Set 1:00, start, one tick → 0:59. min_inc during RUN → still 0:59.
- RUN at 0:30: start edge and tick in the same cycle → PAUSE at 0:30. Tick in PAUSE → unchanged. Start → RUN.
- Editing:
  - seconds: sec_dec at 0 → 59; sec_inc at 59 → 0, minutes unchanged.
  - minutes: min_dec at 0 → 0; 100 min_inc → 99.
  - cancel: sec_inc and sec_dec together → no change.
- Start at 0:00 in IDLE → stays IDLE. Start_i held high through reset release → no RUN.
- Reset asserted in RUN at 0:42 → next cycle state IDLE, time 0:00, alarm=0, running=0.
